// File: rtl/io_dma_master.sv
// Block-copy initiator for the J1 I/O bus: reads 16-bit words from one address
// window and writes them to another, with optional address increment on either side.
module io_dma_master #(
    parameter int unsigned RD_WAIT = 0,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   src_addr,
    input  logic [15:0]   dst_addr,
    input  logic [CW-1:0] count,
    input  logic          src_inc,
    input  logic          dst_inc,
    input  logic [15:0]   io_din,
    output logic [15:0]   io_addr,
    output logic          io_rd,
    output logic          io_wr,
    output logic [15:0]   io_dout,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] xfer_cnt
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RGAP  = 3'd2,
        S_WRITE = 3'd3,
        S_WGAP  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t          r_state,   w_state;
    logic [AW-1:0]   r_src,     w_src;
    logic [AW-1:0]   r_dst,     w_dst;
    logic [CW-1:0]   r_cnt,     w_cnt;
    logic            r_sinc,    w_sinc;
    logic            r_dinc,    w_dinc;
    logic [WW-1:0]   r_wait,    w_wait;
    logic [DW-1:0]   r_data,    w_data;
    logic [CW-1:0]   r_xfer,    w_xfer;
    logic            r_aborted, w_aborted;
    logic [AW-1:0]   r_io_addr, w_io_addr;
    logic [DW-1:0]   r_io_dout, w_io_dout;
    logic            r_io_rd,   w_io_rd;
    logic            r_io_wr,   w_io_wr;
    logic            r_busy,    w_busy;
    logic            r_done,    w_done;

    // State and datapath register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_sinc    <= 1'b0;
            r_dinc    <= 1'b0;
            r_wait    <= '0;
            r_data    <= '0;
            r_xfer    <= '0;
            r_aborted <= 1'b0;
            r_io_addr <= '0;
            r_io_dout <= '0;
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_src     <= w_src;
            r_dst     <= w_dst;
            r_cnt     <= w_cnt;
            r_sinc    <= w_sinc;
            r_dinc    <= w_dinc;
            r_wait    <= w_wait;
            r_data    <= w_data;
            r_xfer    <= w_xfer;
            r_aborted <= w_aborted;
            r_io_addr <= w_io_addr;
            r_io_dout <= w_io_dout;
            r_io_rd   <= w_io_rd;
            r_io_wr   <= w_io_wr;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Next state, datapath updates, and bus outputs decoded from the next state
    always_comb begin
        w_state   = r_state;
        w_src     = r_src;
        w_dst     = r_dst;
        w_cnt     = r_cnt;
        w_sinc    = r_sinc;
        w_dinc    = r_dinc;
        w_wait    = r_wait;
        w_data    = r_data;
        w_xfer    = r_xfer;
        w_aborted = r_aborted;
        w_io_addr = r_io_addr;
        w_io_dout = r_io_dout;
        w_io_rd   = 1'b0;
        w_io_wr   = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_src     = src_addr;
                    w_dst     = dst_addr;
                    w_cnt     = count;
                    w_sinc    = src_inc;
                    w_dinc    = dst_inc;
                    w_xfer    = '0;
                    w_aborted = 1'b0;
                    w_wait    = '0;
                    w_state   = (count == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    w_state   = S_FIN;
                    w_aborted = 1'b1;
                    w_wait    = '0;
                end else if (r_wait == WW'(RD_WAIT)) begin
                    w_data  = io_din;
                    w_src   = r_src + AW'(r_sinc);
                    w_wait  = '0;
                    w_state = S_RGAP;
                end else begin
                    w_wait = r_wait + WW'(1);
                end
            end
            S_RGAP: begin
                if (abort) begin
                    w_state   = S_FIN;
                    w_aborted = 1'b1;
                end else begin
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write has already been driven, so it counts even when aborting
                w_dst  = r_dst + AW'(r_dinc);
                w_xfer = r_xfer + CW'(1);
                if (abort) begin
                    w_state   = S_FIN;
                    w_aborted = 1'b1;
                end else begin
                    w_state = S_WGAP;
                end
            end
            S_WGAP: begin
                if (abort) begin
                    w_state   = S_FIN;
                    w_aborted = 1'b1;
                end else if (r_xfer == r_cnt) begin
                    w_state = S_FIN;
                end else begin
                    w_state = S_READ;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_io_rd = (w_state == S_READ);
        w_io_wr = (w_state == S_WRITE);
        w_done  = (w_state == S_FIN);
        w_busy  = (w_state != S_IDLE);
        // Address holds through gap and FIN states; the bus idles at zero
        case (w_state)
            S_IDLE:  begin
                w_io_addr = '0;
                w_io_dout = '0;
            end
            S_READ:  w_io_addr = w_src;
            S_WRITE: begin
                w_io_addr = w_dst;
                w_io_dout = w_data;
            end
            default: w_io_addr = r_io_addr;
        endcase
    end

    assign io_addr  = r_io_addr;
    assign io_rd    = r_io_rd;
    assign io_wr    = r_io_wr;
    assign io_dout  = r_io_dout;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign xfer_cnt = r_xfer;

endmodule
